// File: rtl/vga_pkg.sv
// vga_pkg: shared FSM states, 640x480@60 timing constants and MISR definition for the frame monitor
package vga_pkg;
    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } state_e;

    localparam int H_TOTAL_640  = 800;
    localparam int V_TOTAL_640  = 525;
    localparam int H_SYNC_640   = 96;
    localparam int V_SYNC_640   = 2;
    localparam int H_BP_640     = 48;
    localparam int V_BP_640     = 33;
    localparam int H_ACTIVE_640 = 640;
    localparam int V_ACTIVE_640 = 480;

    localparam logic [15:0] MISR_POLY = 16'h1021;
    localparam logic [15:0] MISR_SEED = 16'hFFFF;

    function automatic logic [15:0] misr_next(input logic [15:0] s, input logic [2:0] d);
        return {s[14:0], 1'b0} ^ (s[15] ? MISR_POLY : 16'h0000) ^ {13'b0, d};
    endfunction
endpackage

// File: rtl/vga_misr.sv
// vga_misr: 16-bit signature register with seed load and enable, folding in 3-bit pixel data
module vga_misr
    import vga_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        en_i,
    input  logic        load_i,
    input  logic [2:0]  data_i,
    output logic [15:0] sig_o
);
    logic [15:0] sig_q, sig_d;

    always_comb sig_d = load_i ? MISR_SEED : en_i ? misr_next(sig_q, data_i) : sig_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) sig_q <= MISR_SEED;
        else sig_q <= sig_d;
    end

    assign sig_o = sig_q;
endmodule

// File: rtl/vga_frame_monitor.sv
// vga_frame_monitor: recovers VGA line/frame timing and reports per-frame signature, lit count and lock status
module vga_frame_monitor
    import vga_pkg::*;
#(
    parameter bit SYNC_POL    = 1'b0,
    parameter int SYNC_STAGES = 2,
    parameter int H_START     = H_SYNC_640 + H_BP_640,
    parameter int H_ACTIVE    = H_ACTIVE_640,
    parameter int V_START     = V_SYNC_640 + V_BP_640,
    parameter int V_ACTIVE    = V_ACTIVE_640
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        hsync,
    input  logic        vsync,
    input  logic [2:0]  rgb,
    input  logic        err_clr,
    output logic        locked,
    output logic        frame_done,
    output logic [10:0] h_total,
    output logic [9:0]  v_total,
    output logic [15:0] signature,
    output logic [18:0] lit_count,
    output logic        err_h,
    output logic        err_v
);
    localparam logic [4:0]  SYNC_IDLE = {~SYNC_POL, ~SYNC_POL, 3'b000};
    localparam logic [10:0] H_LO = 11'(H_START);
    localparam logic [10:0] H_HI = 11'(H_START + H_ACTIVE);
    localparam logic [9:0]  V_LO = 10'(V_START);
    localparam logic [9:0]  V_HI = 10'(V_START + V_ACTIVE);

    logic [4:0]  sync_q [SYNC_STAGES];
    logic [1:0]  prev_q;
    logic        hs_s, vs_s, h_edge, v_edge, h_sat, active, lock;
    logic [2:0]  rgb_s;
    logic [10:0] hcnt_q, hcnt_d, line_len, h_total_q, h_total_d, cand_h_q, cand_h_d;
    logic [9:0]  vcnt_q, vcnt_d, v_len, v_total_q, v_total_d, cand_v_q, cand_v_d;
    logic [18:0] lit_q, lit_d, lit_count_q, lit_count_d;
    logic [15:0] sig, signature_q, signature_d;
    logic        frame_done_q, frame_done_d, err_h_q, err_h_d, err_v_q, err_v_d;
    state_e      state_q, state_d;

    // rgb travels through the same synchronizer as the syncs so pixels stay aligned with the counters
    assign {hs_s, vs_s, rgb_s} = sync_q[SYNC_STAGES-1];
    assign h_edge   = hs_s == SYNC_POL && prev_q[1] != SYNC_POL;
    assign v_edge   = vs_s == SYNC_POL && prev_q[0] != SYNC_POL;
    assign h_sat    = &hcnt_q && !h_edge;
    assign line_len = hcnt_q + 11'd1;
    assign v_len    = vcnt_q + 10'd1;
    assign lock     = state_q == LOCKED;
    assign active   = hcnt_q >= H_LO && hcnt_q < H_HI && vcnt_q >= V_LO && vcnt_q < V_HI;

    vga_misr u_misr (
        .clk    (clk),
        .reset  (reset),
        .en_i   (active),
        .load_i (v_edge),
        .data_i (rgb_s),
        .sig_o  (sig)
    );

    always_comb begin
        hcnt_d = h_edge ? 11'd0 : &hcnt_q ? hcnt_q : line_len;
        vcnt_d = v_edge ? 10'd0 : (h_edge && !(&vcnt_q)) ? v_len : vcnt_q;
        lit_d  = v_edge ? 19'd0 : active ? lit_q + 19'(|rgb_s) : lit_q;
        err_h_d = (lock && h_edge && line_len != h_total_q) || (err_h_q && !err_clr);
        err_v_d = (lock && v_edge && v_len != v_total_q) || (err_v_q && !err_clr);
    end

    always_comb begin
        state_d      = state_q;
        cand_h_d     = cand_h_q;
        cand_v_d     = cand_v_q;
        h_total_d    = (h_edge && !lock) ? line_len : h_total_q;
        v_total_d    = v_total_q;
        signature_d  = signature_q;
        lit_count_d  = lit_count_q;
        frame_done_d = 1'b0;
        if (v_edge && state_q != SEARCH) begin
            frame_done_d = 1'b1;
            signature_d  = sig;
            lit_count_d  = lit_q;
            if (!lock) v_total_d = v_len;
        end
        if (v_edge) begin
            if (state_q == SEARCH) begin
                state_d = MEASURE;
            end else if (state_q == MEASURE) begin
                cand_h_d = h_total_q;
                cand_v_d = v_len;
                if (h_total_q == cand_h_q && v_len == cand_v_q) state_d = LOCKED;
            end else if (v_len != v_total_q) begin
                state_d  = MEASURE;
                cand_h_d = h_total_q;
                cand_v_d = v_len;
            end
        end
        // lost line timing: forget the last capture so relock needs two fresh matching frames
        if (h_sat) begin
            state_d  = SEARCH;
            cand_h_d = 11'd0;
            cand_v_d = 10'd0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= SYNC_IDLE;
            prev_q <= {2{~SYNC_POL}};
        end else begin
            sync_q[0] <= {hsync, vsync, rgb};
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            prev_q <= {hs_s, vs_s};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= SEARCH;
            hcnt_q       <= '0;
            vcnt_q       <= '0;
            lit_q        <= '0;
            cand_h_q     <= '0;
            cand_v_q     <= '0;
            h_total_q    <= '0;
            v_total_q    <= '0;
            signature_q  <= '0;
            lit_count_q  <= '0;
            frame_done_q <= 1'b0;
            err_h_q      <= 1'b0;
            err_v_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            hcnt_q       <= hcnt_d;
            vcnt_q       <= vcnt_d;
            lit_q        <= lit_d;
            cand_h_q     <= cand_h_d;
            cand_v_q     <= cand_v_d;
            h_total_q    <= h_total_d;
            v_total_q    <= v_total_d;
            signature_q  <= signature_d;
            lit_count_q  <= lit_count_d;
            frame_done_q <= frame_done_d;
            err_h_q      <= err_h_d;
            err_v_q      <= err_v_d;
        end
    end

    assign locked     = lock;
    assign frame_done = frame_done_q;
    assign h_total    = h_total_q;
    assign v_total    = v_total_q;
    assign signature  = signature_q;
    assign lit_count  = lit_count_q;
    assign err_h      = err_h_q;
    assign err_v      = err_v_q;
endmodule

// File: tb/tb_vga_frame_monitor.sv
// tb_vga_frame_monitor: scoreboard bench driving a scaled-down VGA raster (16x8 clocks/lines per frame)
module tb_vga_frame_monitor;
    localparam int HS = 4, HA = 8, VS = 2, VA = 3, L = 16, NL = 8;

    logic        clk = 1'b0, reset = 1'b1, hsync = 1'b1, vsync = 1'b1, err_clr = 1'b0;
    logic [2:0]  rgb = 3'b000;
    logic        locked, frame_done, err_h, err_v;
    logic [10:0] h_total;
    logic [9:0]  v_total;
    logic [15:0] signature;
    logic [18:0] lit_count;

    always #5 clk = ~clk;

    vga_frame_monitor #(
        .SYNC_POL(1'b0), .SYNC_STAGES(2), .H_START(HS), .H_ACTIVE(HA), .V_START(VS), .V_ACTIVE(VA)
    ) dut (
        .clk(clk), .reset(reset), .hsync(hsync), .vsync(vsync), .rgb(rgb), .err_clr(err_clr),
        .locked(locked), .frame_done(frame_done), .h_total(h_total), .v_total(v_total),
        .signature(signature), .lit_count(lit_count), .err_h(err_h), .err_v(err_v)
    );

    typedef struct packed {
        logic        lk;
        logic [9:0]  vt;
        logic [15:0] sig;
        logic [18:0] lit;
    } exp_t;

    exp_t q[$];
    int   total = 0, bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, want);
        end
    endtask

    function automatic logic [2:0] pix(input int mode, input int x, input int y);
        if (mode == 1) return 3'b111;
        if (mode == 2 && x == 0 && y == 0) return 3'b001;
        if (mode == 3 && x == HA - 1 && y == VA - 1) return 3'b001;
        return 3'b000;
    endfunction

    function automatic exp_t model(input int mode, input logic lk);
        logic [15:0] s;
        logic [18:0] n;
        logic [2:0]  p;
        s = 16'hFFFF;
        n = '0;
        for (int y = 0; y < VA; y++)
            for (int x = 0; x < HA; x++) begin
                p = pix(mode, x, y);
                s = {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ {13'b0, p};
                n = n + 19'(p != 3'b000);
            end
        return '{lk, 10'(NL), s, n};
    endfunction

    // counters start one raw clock after the sync edge, so active pixel x sits at raw column HS+1+x
    task automatic frame(input int mode, input int lines, input int long_row, input int clr_row,
                         input bit rep, input logic lk);
        for (int r = 0; r < lines; r++) begin
            int len;
            len = (r == long_row) ? L + 1 : L;
            for (int c = 0; c < len; c++) begin
                @(negedge clk);
                if (r == clr_row && c == 5) chk("err_h_before_clr", err_h, 1);
                hsync   = c >= 2;
                vsync   = r != 0;
                rgb     = (r >= VS && r < VS + VA && c - 1 >= HS && c - 1 < HS + HA) ?
                          pix(mode, c - 1 - HS, r - VS) : 3'b000;
                err_clr = r == clr_row && c == 5;
            end
        end
        if (rep) q.push_back(model(mode, lk));
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            hsync = 1'b1;
            vsync = 1'b1;
            rgb   = 3'b000;
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_locked"}, locked, 0);
        chk({tag, "_frame_done"}, frame_done, 0);
        chk({tag, "_h_total"}, h_total, 0);
        chk({tag, "_v_total"}, v_total, 0);
        chk({tag, "_signature"}, signature, 0);
        chk({tag, "_lit_count"}, lit_count, 0);
        chk({tag, "_err_h"}, err_h, 0);
        chk({tag, "_err_v"}, err_v, 0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (frame_done) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL frame_done_unexpected: got 1 want 0");
            end else begin
                e = q.pop_front();
                chk("fd_locked", locked, e.lk);
                chk("fd_h_total", h_total, L);
                chk("fd_v_total", v_total, e.vt);
                chk("fd_signature", signature, e.sig);
                chk("fd_lit_count", lit_count, e.lit);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        chk_zero("reset");
        @(negedge clk);
        reset = 1'b0;
        idle(3);
        frame(0, NL, -1, -1, 1, 0);
        frame(0, NL, -1, -1, 1, 1);
        chk("locked_after_2_edges", locked, 0);
        frame(0, NL, -1, -1, 1, 1);
        chk("locked_after_3_edges", locked, 1);
        frame(0, NL, -1, -1, 1, 1);
        frame(1, NL, -1, -1, 1, 1);
        frame(1, NL, -1, -1, 1, 1);
        frame(2, NL, -1, -1, 1, 1);
        frame(3, NL, -1, -1, 1, 1);
        frame(0, NL, 7, -1, 1, 1);
        frame(0, NL - 1, -1, 3, 1, 0);
        chk("err_h_after_clr", err_h, 0);
        chk("err_v_before_short", err_v, 0);
        frame(0, NL, -1, -1, 1, 0);
        chk("err_v_after_short", err_v, 1);
        chk("locked_after_short", locked, 0);
        frame(0, NL, -1, -1, 1, 1);
        frame(0, NL, -1, -1, 0, 1);
        chk("relocked", locked, 1);
        idle(2100);
        chk("locked_after_hsync_loss", locked, 0);
        chk("err_v_sticky", err_v, 1);
        frame(1, NL, -1, -1, 1, 0);
        frame(1, NL, -1, -1, 1, 1);
        chk("locked_after_2_edges_restore", locked, 0);
        frame(1, NL, -1, -1, 1, 1);
        chk("locked_after_3_edges_restore", locked, 1);
        frame(2, NL, -1, -1, 1, 1);
        frame(1, 4, -1, -1, 0, 0);
        idle(5);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk_zero("midreset");
        repeat (3) @(negedge clk);
        reset = 1'b0;
        idle(2);
        frame(3, NL, -1, -1, 1, 0);
        frame(0, NL, -1, -1, 1, 1);
        frame(0, NL, -1, -1, 0, 1);
        chk("locked_final", locked, 1);
        idle(20);
        chk("queue_empty", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
